// File: rtl/mux_ctrl_pkg.sv
// Shared select/priority definitions for the two-requester mux arbiter.
package mux_ctrl_pkg;

   localparam logic GRANT_I0 = 1'b0;
   localparam logic GRANT_I1 = 1'b1;

   // PRI0: requester 0 wins a tie (last grant went to requester 1).
   typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

   localparam pri_t PRI_RST = PRI0;
   localparam logic SEL_RST = GRANT_I0;

endpackage

// File: rtl/Mux2x4.sv
// 2:1 mux on 4-bit words; purely combinational, no backpressure.
module Mux2x4 (
   input  logic [3:0] I0,
   input  logic [3:0] I1,
   input  logic       S,
   output logic [3:0] O
);

   assign O = S ? I1 : I0;

endmodule

// File: rtl/mux2x4_arbiter.sv
// Round-robin arbiter feeding a shared Mux2x4 into a one-entry output register; 1-cycle latency.
// Readies drop while the output register is full and not drained; drain and refill share one edge.
module mux2x4_arbiter
   import mux_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   input  logic             I0_valid,
   input  logic [WIDTH-1:0] I0_data,
   output logic             I0_ready,
   input  logic             I1_valid,
   input  logic [WIDTH-1:0] I1_data,
   output logic             I1_ready,
   output logic             O_valid,
   output logic [WIDTH-1:0] O_data,
   input  logic             O_ready,
   output logic             S,
   output logic [CNT_W-1:0] CNT0,
   output logic [CNT_W-1:0] CNT1
);

   generate
      if (WIDTH != 4) begin : g_width_err
         $error("mux2x4_arbiter: WIDTH must be 4 to match Mux2x4");
      end
   endgenerate

   pri_t             state_q, state_d;
   logic             s_q;
   logic             sel;
   logic             load;
   logic             accept;
   logic [3:0]       mux_o;
   logic             o_valid_q;
   logic [WIDTH-1:0] o_data_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   assign load = !o_valid_q || O_ready;

   always_comb begin
      sel      = s_q;
      state_d  = state_q;
      I0_ready = 1'b0;
      I1_ready = 1'b0;
      if (I0_valid && I1_valid)
         sel = (state_q == PRI1) ? GRANT_I1 : GRANT_I0;
      else if (I0_valid)
         sel = GRANT_I0;
      else if (I1_valid)
         sel = GRANT_I1;
      if (!ASYNCRESET) begin
         I0_ready = load && I0_valid && (sel == GRANT_I0);
         I1_ready = load && I1_valid && (sel == GRANT_I1);
      end
      accept = I0_ready || I1_ready;
      // Favour whichever requester was not just granted.
      if (accept)
         state_d = (sel == GRANT_I1) ? PRI0 : PRI1;
   end

   Mux2x4 u_mux (
      .I0 (I0_data),
      .I1 (I1_data),
      .S  (sel),
      .O  (mux_o)
   );

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state_q   <= PRI_RST;
         s_q       <= SEL_RST;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= sel;
         if (accept) begin
            o_valid_q <= 1'b1;
            o_data_q  <= mux_o;
            if (I0_ready) cnt0_q <= cnt0_q + CNT_W'(1);
            if (I1_ready) cnt1_q <= cnt1_q + CNT_W'(1);
         end else if (O_ready) begin
            o_valid_q <= 1'b0;
         end
      end
   end

   assign S       = sel;
   assign O_valid = o_valid_q;
   assign O_data  = o_data_q;
   assign CNT0    = cnt0_q;
   assign CNT1    = cnt1_q;

endmodule

// File: tb/tb_mux2x4_arbiter.sv
// Directed bench for mux2x4_arbiter with hand-computed expectations.
module tb_mux2x4_arbiter;

   logic       CLK = 1'b0;
   logic       ASYNCRESET = 1'b0;
   logic       I0_valid = 1'b0;
   logic [3:0] I0_data = 4'h0;
   logic       I0_ready;
   logic       I1_valid = 1'b0;
   logic [3:0] I1_data = 4'h0;
   logic       I1_ready;
   logic       O_valid;
   logic [3:0] O_data;
   logic       O_ready = 1'b0;
   logic       S;
   logic [7:0] CNT0;
   logic [7:0] CNT1;

   int n_tests = 0;
   int n_fail  = 0;

   mux2x4_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
      .CLK        (CLK),
      .ASYNCRESET (ASYNCRESET),
      .I0_valid   (I0_valid),
      .I0_data    (I0_data),
      .I0_ready   (I0_ready),
      .I1_valid   (I1_valid),
      .I1_data    (I1_data),
      .I1_ready   (I1_ready),
      .O_valid    (O_valid),
      .O_data     (O_data),
      .O_ready    (O_ready),
      .S          (S),
      .CNT0       (CNT0),
      .CNT1       (CNT1)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   localparam logic [3:0] CONT_EXP [4] = '{4'h3, 4'hC, 4'h3, 4'hC};

   initial begin
      // Reset values
      #1 ASYNCRESET = 1'b1;
      #1;
      check("rst_ovalid", 32'(O_valid), 0);
      check("rst_odata",  32'(O_data),  0);
      check("rst_s",      32'(S),       0);
      check("rst_cnt0",   32'(CNT0),    0);
      check("rst_cnt1",   32'(CNT1),    0);
      check("rst_rdy0",   32'(I0_ready), 0);
      check("rst_rdy1",   32'(I1_ready), 0);
      step();
      step();
      ASYNCRESET = 1'b0;

      // Single requester 1
      I1_valid = 1'b1; I1_data = 4'h5; O_ready = 1'b1;
      #1;
      check("single_s",    32'(S),        1);
      check("single_rdy1", 32'(I1_ready), 1);
      check("single_rdy0", 32'(I0_ready), 0);
      step();
      check("single_ovalid", 32'(O_valid), 1);
      check("single_odata",  32'(O_data),  4'h5);
      check("single_cnt1",   32'(CNT1),    1);

      // No request: select holds last pick, output drains
      I1_valid = 1'b0;
      #1;
      check("hold_s", 32'(S), 1);
      step();
      check("drain_ovalid", 32'(O_valid), 0);
      check("hold_cnt1",    32'(CNT1),    1);

      // Contention: grants alternate starting with requester 0
      I0_valid = 1'b1; I0_data = 4'h3;
      I1_valid = 1'b1; I1_data = 4'hC;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_rdy0", 32'(I0_ready), (i % 2 == 0) ? 1 : 0);
         check("cont_rdy1", 32'(I1_ready), (i % 2 == 0) ? 0 : 1);
         step();
         check("cont_odata", 32'(O_data), 32'(CONT_EXP[i]));
      end
      check("cont_cnt0", 32'(CNT0), 2);
      check("cont_cnt1", 32'(CNT1), 3);

      // Backpressure: O holds C, readies low
      I1_valid = 1'b0; I0_data = 4'h9; O_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_rdy0",   32'(I0_ready), 0);
         check("bp_rdy1",   32'(I1_ready), 0);
         check("bp_odata",  32'(O_data),   4'hC);
         check("bp_ovalid", 32'(O_valid),  1);
         step();
      end
      O_ready = 1'b1;
      #1;
      check("bp_refill_rdy0", 32'(I0_ready), 1);
      step();
      check("bp_refill_odata",  32'(O_data),  4'h9);
      check("bp_refill_ovalid", 32'(O_valid), 1);
      check("bp_refill_cnt0",   32'(CNT0),    3);
      I0_valid = 1'b0;
      step();
      check("bp_empty_ovalid", 32'(O_valid), 0);

      // Reset mid-transfer: word A held under backpressure, then async reset
      I0_valid = 1'b1; I0_data = 4'hA; O_ready = 1'b0;
      step();
      check("mid_pre_odata", 32'(O_data), 4'hA);
      check("mid_pre_cnt0",  32'(CNT0),   4);
      I1_valid = 1'b1;
      #2 ASYNCRESET = 1'b1;
      #1;
      check("mid_ovalid", 32'(O_valid),  0);
      check("mid_odata",  32'(O_data),   0);
      check("mid_cnt0",   32'(CNT0),     0);
      check("mid_cnt1",   32'(CNT1),     0);
      check("mid_rdy0",   32'(I0_ready), 0);
      check("mid_rdy1",   32'(I1_ready), 0);
      #1 ASYNCRESET = 1'b0;
      #1;
      check("post_rst_s",    32'(S),        0);
      check("post_rst_rdy0", 32'(I0_ready), 1);
      check("post_rst_rdy1", 32'(I1_ready), 0);
      step();
      check("post_rst_odata", 32'(O_data), 4'hA);
      check("post_rst_cnt0",  32'(CNT0),   1);

      // Counter wrap on requester 0 only
      I1_valid = 1'b0; O_ready = 1'b1;
      for (int i = 0; i < 254; i++) step();
      check("wrap_cnt0_255", 32'(CNT0), 255);
      step();
      check("wrap_cnt0_0",   32'(CNT0), 0);
      check("wrap_cnt1",     32'(CNT1), 0);
      step();
      check("wrap_cnt0_1",   32'(CNT0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux2x4_arbiter.md
# mux2x4_arbiter

Round-robin arbiter and output-register controller that shares one `Mux2x4` datapath between two 4-bit valid/ready requesters. It drives the mux select, registers the selected word into a one-entry output stage, and counts accepted transfers per requester. It sits between two producers and a single downstream consumer on the 4-bit bus.

## Interface
Parameters:
- `WIDTH`, default 4. Data width. Fixed at 4 to match `Mux2x4`; any other value is a synthesis error.
- `CNT_W`, default 8. Width of each per-requester transfer counter.

Ports:
- `CLK` in 1: single clock. Everything is rising-edge.
- `ASYNCRESET` in 1: asynchronous reset, active-high.
- `I0_valid` in 1: requester 0 holds a word.
- `I0_data` in `WIDTH`: requester 0 word.
- `I0_ready` out 1: requester 0 word is accepted this cycle.
- `I1_valid` in 1: requester 1 holds a word.
- `I1_data` in `WIDTH`: requester 1 word.
- `I1_ready` out 1: requester 1 word is accepted this cycle.
- `O_valid` out 1: the output register holds a word.
- `O_data` out `WIDTH`: registered output word.
- `O_ready` in 1: the consumer takes `O_data` this cycle.
- `S` out 1: current mux select (0 = `I0_data`, 1 = `I1_data`).
- `CNT0` out `CNT_W`: number of accepted requester-0 transfers.
- `CNT1` out `CNT_W`: number of accepted requester-1 transfers.

## Operation
Load rule:
- `load = !O_valid || O_ready`. The output register is empty or is being drained this cycle.

Priority state, 2 states:
- `PRI0` means the last grant went to requester 1, so requester 0 wins a tie. `PRI1` is the mirror case.
- Reset state is `PRI0`.

Select and grant:
- Pick: if only one request is valid, pick it. If both are valid, pick the requester favoured by the current state. If neither is valid, hold `S` at its previous pick.
- `S` is combinational from the valids and the state.
- `Ix_ready = load && Ix_valid && (S == x)`. At most one ready is high per cycle.
- `Ix_ready` depends combinationally on `O_ready`.

Accept (`I0_ready || I1_ready`):
- `O_data <= Mux2x4(I0_data, I1_data, S)` and `O_valid <= 1`.
- The state moves to favour the non-granted requester.
- The granted counter increments, wrapping 2^CNT_W−1 → 0.

No accept:
- If `O_ready` is high, `O_valid <= 0`.
- Otherwise `O_data` and `O_valid` hold.
- The state and counters hold.

Reset:
- Mid-operation reset discards any held word.
- `O_valid`, `O_data`, `CNT0` and `CNT1` clear to 0, the state returns to `PRI0`, and the held `S` clears to 0.
- `I0_ready` and `I1_ready` are forced to 0 while `ASYNCRESET` is high.

## Timing
- Reset values: `O_valid` = 0, `O_data` = 0, `S` = 0, `CNT0` = 0, `CNT1` = 0, `I0_ready` = 0, `I1_ready` = 0.
- Latency is 1 cycle, from the accept edge to `O_valid`/`O_data` being visible.
- Throughput is one word per cycle while `O_ready` stays high. Simultaneous drain and refill in the same cycle produces no bubble.
- Backpressure: while `O_valid && !O_ready`, both readies are low. `O_data` is stable and requesters must hold `valid`/`data`.
- When both requesters are continuously valid, grants strictly alternate.
- Counter wrap happens on the accepting edge, with no sticky flag.

## Structure
- The shared package `mux_ctrl_pkg` holds:
  - constants `GRANT_I0 = 1'b0` and `GRANT_I1 = 1'b1`;
  - the priority-state enum `{PRI0, PRI1}`;
  - the reset constants for the state and select.
- One sub-module instance, the existing `Mux2x4`. `I0 → I0_data`, `I1 → I1_data`, `S → S`, and its `O` feeds the output register D input.
- The arbiter logic, output register and counters stay in this module. There is no further sub-module.

## Test plan
- **Reset mid-transfer:** set `I0_valid`=1 with `I0_data`=4'hA and hold `O_ready`=0. Assert `ASYNCRESET` without a clock edge. Required: `O_valid`=0, `O_data`=0, `CNT0`=0 and both readies 0 immediately. After release, the first accept goes to requester 0.
- **Single requester:** `I1_valid`=1 with `I1_data`=4'h5, `O_ready`=1. Required: `S`=1, `I1_ready`=1, and the next cycle `O_valid`=1 with `O_data`=4'h5 and `CNT1`=1.
- **Contention:** both valid (`I0_data`=4'h3, `I1_data`=4'hC) for 4 cycles with `O_ready`=1. Required: outputs 3, C, 3, C, and `CNT0`=`CNT1`=2.
- **Backpressure:** after one accept, hold `O_ready`=0 for 3 cycles. Required: `O_data` is stable and both readies stay 0. Raise `O_ready`: drain and the next accept occur on the same edge.
- **Counter wrap:** make 256 requester-0 accepts with `CNT_W`=8. Required: `CNT0` goes 255 → 0 and `CNT1` is unchanged.
